uart_fifo_ng: RTL and testbench
===============================

Name: uart_fifo_ng

Overview:
- Parametrised successor to the single-byte uart: configurable frame format (5–8 data bits, parity none/even/odd, 1 or 2 stop bits) and independent power-of-two RX and TX FIFOs.
- Sits between a Wishbone peripheral wrapper (or testbench comm partner) and the board pins.
- Same rx_data/rx_avail/rx_ack and tx_data/tx_wr/tx_busy handshake as the existing uart, plus FIFO status and sticky error flags.

Parameters:
- freq_hz, 100000000, system clock frequency in Hz
- baud, 115200, line rate
- data_bits, 8, data bits per frame, 5..8
- parity, 0, 0=none 1=even 2=odd
- stop_bits, 1, 1 or 2
- fifo_aw, 4, log2 FIFO depth; RX and TX each hold 2**fifo_aw bytes

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- uart_rxd  in  1  serial input; idle high
- uart_txd  out  1  serial output; idle high
- rx_data  out  8  RX FIFO head; unused upper bits 0
- rx_avail  out  1  RX FIFO not empty
- rx_ack  in  1  pop RX head
- rx_level  out  fifo_aw+1  RX FIFO occupancy
- tx_data  in  8  byte to send; bits above data_bits ignored
- tx_wr  in  1  push tx_data
- tx_busy  out  1  TX FIFO not empty or shifter active
- tx_full  out  1  TX FIFO full
- err_clr  in  1  clear all sticky errors
- rx_frame_err  out  1  sticky: stop bit sampled 0
- rx_parity_err  out  1  sticky: parity mismatch
- rx_overrun  out  1  sticky: byte received with RX FIFO full
- tx_drop  out  1  sticky: tx_wr while tx_full

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - uart_txd=1; FIFOs empty, so rx_avail=0, rx_level=0, tx_busy=0, tx_full=0.
  - rx_data=0; all sticky flags 0.
  - Any frame in progress is abandoned.
  - After release, the receiver waits for a 1 on uart_rxd before it arms start detection.
- Baud tick:
  - divisor = freq_hz/(baud*16), integer truncation, minimum 1.
  - A free-running counter produces a 1-clk enable every divisor clocks. This is 16x oversampling.
- RX FSM: IDLE -> START -> DATA -> PARITY (only if parity≠0) -> STOP -> IDLE.
  - IDLE: the first tick with rxd=0 enters START.
  - START: samples at 8 ticks. If rxd=1 there, it is a glitch: return to IDLE with no flags.
  - DATA and later bits: each bit sampled 16 ticks after the previous sample, LSB first.
  - Input passes through a 2-flop synchroniser before the FSM.
  - Only one stop bit is checked on RX, even when stop_bits=2.
  - At the STOP sample: the byte is pushed if the FIFO is not full. If the FIFO is full, the byte is discarded and rx_overrun is set.
  - A framing error sets rx_frame_err; a parity error sets rx_parity_err. The byte is still pushed in both cases.
  - Frame and parity flags are not mutually exclusive.
  - The push takes effect on the next clk: rx_avail rises 1 clk after the stop sample.
- RX FIFO:
  - rx_data shows the head combinationally from registered storage.
  - rx_ack with rx_avail=0 is ignored.
  - Simultaneous push and pop on the same clk: level unchanged, both take effect.
  - A push on a full FIFO with a simultaneous pop is accepted; no overrun.
- TX path:
  - tx_wr when not full pushes the byte.
  - tx_wr when full drops the byte and sets tx_drop.
  - Simultaneous tx_wr and a shifter pop on a full FIFO is accepted.
  - TX FSM: IDLE -> START -> DATA -> PARITY? -> STOP(xstop_bits) -> IDLE. Each bit lasts 16 ticks.
  - IDLE pops the FIFO on the first tick it sees data.
  - Back-to-back frames have no extra idle bit.
  - tx_busy drops the clk after the last stop bit ends with the FIFO empty.
- Parity: even means data bits plus parity bit hold an even number of 1s; odd is the inverse.
- Errors:
  - err_clr clears all sticky flags.
  - If a set event and err_clr occur on the same clk, set wins.
- Reset mid-operation: TX and RX FSMs both return to IDLE; uart_txd goes high that clk; FIFO contents are discarded.

Test Plan:
- Loopback, 8N1, freq_hz=16000000, baud=1000000 (divisor 1, 16 clk/bit), txd tied to rxd: write 0xA5, 0x3C -> on uart_txd, start bit at 16 clk and full frame 160 clk. rx_avail rises, rx_data=A5; after rx_ack, 3C; then rx_avail=0 with no errors.
- data_bits=7, parity=2 (odd), stop_bits=2: send 0x41 -> line bits 0, 1000001, parity 1, 1, 1 = 176 clk. Injected frame carrying parity 0 -> rx_data=41, rx_parity_err=1.
- Framing: drive a frame with stop bit 0 -> rx_frame_err=1 and byte still queued. err_clr -> flag 0. err_clr on the same clk as a new error -> flag stays 1.
- Overrun, fifo_aw=2: receive 5 bytes 01..05 with no ack -> rx_level=4, rx_overrun=1, and the FIFO reads 01,02,03,04.
- TX full, fifo_aw=2: 6 consecutive tx_wr -> 1 popped into the shifter and 4 queued, so tx_full=1. The 6th sets tx_drop. tx_busy stays high for 5 frames, then falls.
- Glitch and reset: 3-clk low pulse on rxd -> no byte and no flags. Assert reset_n=0 mid-TX-frame -> uart_txd=1 the next clk, tx_busy=0, and no residual bytes after release.

Source files
------------

// File: rtl/uart_fifo_ng.sv
// Generic synchronous FIFO used for the UART RX and TX byte queues.
// Latency: a push is visible at the head one clk later; the head is read combinationally.
// Backpressure: a push on a full FIFO is refused unless a pop happens the same clk.
module uart_fifo_ng_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic [AW:0]   o_level
);

    logic [W-1:0] r_mem [0:(1<<AW)-1];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push;

    assign o_level    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Pop on empty is ignored; a full FIFO still takes a push when it is popped the same clk.
    assign w_pop      = i_pop && !w_empty;
    assign w_push     = i_push && (!w_full || w_pop);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// UART with configurable frame format, 16x oversampled receiver and RX/TX byte FIFOs.
// Latency: rx_avail rises 1 clk after the stop-bit sample; TX start bit begins the clk after the pop tick.
// Backpressure: none on the line; full RX FIFO drops bytes (rx_overrun), full TX FIFO drops writes (tx_drop).
module uart_fifo_ng #(
    parameter int freq_hz   = 100000000,
    parameter int baud      = 115200,
    parameter int data_bits = 8,
    parameter int parity    = 0,
    parameter int stop_bits = 1,
    parameter int fifo_aw   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               uart_rxd,
    output logic               uart_txd,
    output logic [7:0]         rx_data,
    output logic               rx_avail,
    input  logic               rx_ack,
    output logic [fifo_aw:0]   rx_level,
    input  logic [7:0]         tx_data,
    input  logic               tx_wr,
    output logic               tx_busy,
    output logic               tx_full,
    input  logic               err_clr,
    output logic               rx_frame_err,
    output logic               rx_parity_err,
    output logic               rx_overrun,
    output logic               tx_drop
);

    localparam int DIV_RAW = freq_hz / (baud * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [2:0]    DBIT_LAST = 3'(data_bits - 1);
    localparam logic [7:0]    DMASK     = 8'((16'd1 << data_bits) - 16'd1);
    localparam logic          PAR_EN    = (parity != 0);
    localparam logic          PAR_ODD   = (parity == 2);
    localparam logic          STOP_LAST = (stop_bits == 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    // ---------------- baud tick ----------------
    logic [DW-1:0] r_div_cnt;
    logic          w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // Free-running divider giving a one-clk enable at 16x the line rate.
    always_ff @(posedge clk) begin
        if (!reset_n)    r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + DW'(1);
    end

    // ---------------- RX input conditioning ----------------
    logic r_rxd_s1;
    logic r_rxd_s2;
    logic r_rx_armed;

    // Two-flop synchroniser; reset low so start detection only arms after a real idle 1 is seen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rxd_s1   <= 1'b0;
            r_rxd_s2   <= 1'b0;
            r_rx_armed <= 1'b0;
        end else begin
            r_rxd_s1 <= uart_rxd;
            r_rxd_s2 <= r_rxd_s1;
            if (r_rxd_s2) r_rx_armed <= 1'b1;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t  r_rx_state;
    rx_state_t  w_rx_state_nxt;
    logic [3:0] r_rx_cnt;
    logic [3:0] w_rx_cnt_nxt;
    logic [2:0] r_rx_bit;
    logic [2:0] w_rx_bit_nxt;
    logic [7:0] r_rx_shift;
    logic [7:0] w_rx_shift_nxt;
    logic       r_rx_par;
    logic       w_rx_par_nxt;
    logic       w_rx_push;
    logic       w_rx_ferr;
    logic       w_rx_perr;

    // RX state and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
        end
    end

    // RX next state: half-bit start check, then one sample per 16 ticks; single stop bit checked.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_rx_push      = 1'b0;
        w_rx_ferr      = 1'b0;
        w_rx_perr      = 1'b0;
        if (w_tick) begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_armed && !r_rxd_s2) begin
                        w_rx_state_nxt = RX_START;
                        w_rx_cnt_nxt   = '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == 4'd7) begin
                        w_rx_cnt_nxt   = '0;
                        w_rx_bit_nxt   = '0;
                        w_rx_shift_nxt = '0;
                        // A high line at mid-start is a glitch: drop back silently.
                        w_rx_state_nxt = r_rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_cnt_nxt = '0;
                        w_rx_shift_nxt[r_rx_bit] = r_rxd_s2;
                        if (r_rx_bit == DBIT_LAST)
                            w_rx_state_nxt = PAR_EN ? RX_PAR : RX_STOP;
                        else
                            w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                    end
                end
                RX_PAR: begin
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_cnt_nxt   = '0;
                        w_rx_par_nxt   = r_rxd_s2;
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == 4'd15) begin
                        w_rx_cnt_nxt   = '0;
                        w_rx_state_nxt = RX_IDLE;
                        w_rx_push      = 1'b1;
                        w_rx_ferr      = !r_rxd_s2;
                        w_rx_perr      = PAR_EN && ((^r_rx_shift ^ r_rx_par) != PAR_ODD);
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                    end
                end
                default: w_rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       w_rx_head;
    logic [fifo_aw:0] w_rx_level;
    logic             w_rx_full;
    logic             w_rx_ovr_set;

    uart_fifo_ng_fifo #(.W(8), .AW(fifo_aw)) u_rx_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_rx_push),
        .i_push_dat (r_rx_shift_sel(w_rx_shift_nxt)),
        .i_pop      (rx_ack),
        .o_head_dat (w_rx_head),
        .o_level    (w_rx_level)
    );

    // The byte pushed at the stop sample is the assembled shift register (upper bits already 0).
    function automatic logic [7:0] r_rx_shift_sel(input logic [7:0] v);
        return v;
    endfunction

    assign rx_level     = w_rx_level;
    assign rx_avail     = (w_rx_level != '0);
    assign w_rx_full    = w_rx_level[fifo_aw];
    assign rx_data      = rx_avail ? w_rx_head : 8'h00;
    assign w_rx_ovr_set = w_rx_push && w_rx_full && !rx_ack;

    // ---------------- TX FIFO ----------------
    logic [7:0]       w_tx_head;
    logic [fifo_aw:0] w_tx_level;
    logic             w_tx_empty;
    logic             w_tx_pop;
    logic             w_tx_drop_set;

    uart_fifo_ng_fifo #(.W(8), .AW(fifo_aw)) u_tx_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (tx_wr),
        .i_push_dat (tx_data & DMASK),
        .i_pop      (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_level    (w_tx_level)
    );

    assign w_tx_empty    = (w_tx_level == '0);
    assign tx_full       = w_tx_level[fifo_aw];
    assign w_tx_drop_set = tx_wr && tx_full && !w_tx_pop;

    // ---------------- TX FSM ----------------
    tx_state_t  r_tx_state;
    tx_state_t  w_tx_state_nxt;
    logic [3:0] r_tx_cnt;
    logic [3:0] w_tx_cnt_nxt;
    logic [2:0] r_tx_bit;
    logic [2:0] w_tx_bit_nxt;
    logic [7:0] r_tx_shift;
    logic [7:0] w_tx_shift_nxt;
    logic       r_tx_par;
    logic       w_tx_par_nxt;
    logic       r_tx_stop;
    logic       w_tx_stop_nxt;
    logic       r_txd;
    logic       w_txd_nxt;
    logic       w_tx_load;

    // TX state and registered line output; reset drives the line idle high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_stop  <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_stop  <= w_tx_stop_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // TX next state: 16 ticks per bit; the last stop bit chains straight into the next start bit.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_tx_stop_nxt  = r_tx_stop;
        w_txd_nxt      = r_txd;
        w_tx_load      = 1'b0;
        if (w_tick) begin
            case (r_tx_state)
                TX_IDLE: w_tx_load = !w_tx_empty;
                TX_START: begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_nxt   = '0;
                        w_tx_bit_nxt   = '0;
                        w_txd_nxt      = r_tx_shift[0];
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_tx_state_nxt = TX_DATA;
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_nxt = '0;
                        if (r_tx_bit == DBIT_LAST) begin
                            w_tx_stop_nxt = 1'b0;
                            if (PAR_EN) begin
                                w_txd_nxt      = r_tx_par;
                                w_tx_state_nxt = TX_PAR;
                            end else begin
                                w_txd_nxt      = 1'b1;
                                w_tx_state_nxt = TX_STOP;
                            end
                        end else begin
                            w_tx_bit_nxt   = r_tx_bit + 3'd1;
                            w_txd_nxt      = r_tx_shift[0];
                            w_tx_shift_nxt = r_tx_shift >> 1;
                        end
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                    end
                end
                TX_PAR: begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_nxt   = '0;
                        w_txd_nxt      = 1'b1;
                        w_tx_stop_nxt  = 1'b0;
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == 4'd15) begin
                        w_tx_cnt_nxt = '0;
                        if (r_tx_stop == STOP_LAST) begin
                            if (!w_tx_empty) begin
                                w_tx_load = 1'b1;
                            end else begin
                                w_txd_nxt      = 1'b1;
                                w_tx_state_nxt = TX_IDLE;
                            end
                        end else begin
                            w_tx_stop_nxt = 1'b1;
                        end
                    end else begin
                        w_tx_cnt_nxt = r_tx_cnt + 4'd1;
                    end
                end
                default: w_tx_state_nxt = TX_IDLE;
            endcase
        end
        if (w_tx_load) begin
            w_tx_state_nxt = TX_START;
            w_tx_cnt_nxt   = '0;
            w_txd_nxt      = 1'b0;
            w_tx_shift_nxt = w_tx_head;
            w_tx_par_nxt   = (^w_tx_head) ^ PAR_ODD;
        end
    end

    assign w_tx_pop = w_tx_load;
    assign uart_txd = r_txd;
    assign tx_busy  = !w_tx_empty || (r_tx_state != TX_IDLE);

    // ---------------- sticky errors ----------------
    logic r_rx_frame_err;
    logic r_rx_parity_err;
    logic r_rx_overrun;
    logic r_tx_drop;

    // Sticky flags: a set event wins over a same-clk clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_frame_err  <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_overrun    <= 1'b0;
            r_tx_drop       <= 1'b0;
        end else begin
            if (w_rx_push && w_rx_ferr) r_rx_frame_err <= 1'b1;
            else if (err_clr)           r_rx_frame_err <= 1'b0;
            if (w_rx_push && w_rx_perr) r_rx_parity_err <= 1'b1;
            else if (err_clr)           r_rx_parity_err <= 1'b0;
            if (w_rx_ovr_set)           r_rx_overrun <= 1'b1;
            else if (err_clr)           r_rx_overrun <= 1'b0;
            if (w_tx_drop_set)          r_tx_drop <= 1'b1;
            else if (err_clr)           r_tx_drop <= 1'b0;
        end
    end

    assign rx_frame_err  = r_rx_frame_err;
    assign rx_parity_err = r_rx_parity_err;
    assign rx_overrun    = r_rx_overrun;
    assign tx_drop       = r_tx_drop;

endmodule

// File: tb/tb_uart_fifo_ng.sv
// Directed bench for uart_fifo_ng: 8N1/depth-4 instance (A) with optional loopback, 7O2 instance (B).
// Received bytes are checked against a scoreboard queue filled when the frame is driven.
// Line timing is checked by sampling uart_txd at bit centres relative to the start-bit edge.
module tb_uart_fifo_ng;

    logic clk;
    logic reset_n;

    logic       a_loop, a_rxd_drv, a_rxd, a_txd;
    logic [7:0] a_rx_data, a_tx_data;
    logic       a_rx_avail, a_rx_ack, a_tx_wr, a_tx_busy, a_tx_full, a_err_clr;
    logic [2:0] a_rx_level;
    logic       a_ferr, a_perr, a_ovr, a_drop;

    logic       b_rxd_drv, b_txd;
    logic [7:0] b_rx_data, b_tx_data;
    logic       b_rx_avail, b_rx_ack, b_tx_wr, b_tx_busy, b_tx_full, b_err_clr;
    logic [4:0] b_rx_level;
    logic       b_ferr, b_perr, b_ovr, b_drop;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    assign a_rxd = a_loop ? a_txd : a_rxd_drv;

    uart_fifo_ng #(.freq_hz(16000000), .baud(1000000), .data_bits(8), .parity(0),
                   .stop_bits(1), .fifo_aw(2)) u_a (
        .clk(clk), .reset_n(reset_n), .uart_rxd(a_rxd), .uart_txd(a_txd),
        .rx_data(a_rx_data), .rx_avail(a_rx_avail), .rx_ack(a_rx_ack), .rx_level(a_rx_level),
        .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_busy(a_tx_busy), .tx_full(a_tx_full),
        .err_clr(a_err_clr), .rx_frame_err(a_ferr), .rx_parity_err(a_perr),
        .rx_overrun(a_ovr), .tx_drop(a_drop));

    uart_fifo_ng #(.freq_hz(16000000), .baud(1000000), .data_bits(7), .parity(2),
                   .stop_bits(2), .fifo_aw(4)) u_b (
        .clk(clk), .reset_n(reset_n), .uart_rxd(b_rxd_drv), .uart_txd(b_txd),
        .rx_data(b_rx_data), .rx_avail(b_rx_avail), .rx_ack(b_rx_ack), .rx_level(b_rx_level),
        .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_busy(b_tx_busy), .tx_full(b_tx_full),
        .err_clr(b_err_clr), .rx_frame_err(b_ferr), .rx_parity_err(b_perr),
        .rx_overrun(b_ovr), .tx_drop(b_drop));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a serial frame, LSB of 'bits' first, 16 clk per bit, then return to idle.
    task automatic send_frame(input bit sel, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) b_rxd_drv = bits[i];
            else     a_rxd_drv = bits[i];
            repeat (16) @(negedge clk);
        end
        a_rxd_drv = 1'b1;
        b_rxd_drv = 1'b1;
    endtask

    // Wait (bounded) for a received byte, compare to the scoreboard head, then ack it.
    task automatic pop_rx(input bit sel, input string tag);
        int n;
        logic [7:0] expv;
        n = 0;
        expv = sel ? qb.pop_front() : qa.pop_front();
        while (!(sel ? b_rx_avail : a_rx_avail) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_avail"}, sel ? b_rx_avail : a_rx_avail, 1);
        check(tag, sel ? b_rx_data : a_rx_data, expv);
        if (sel) b_rx_ack = 1'b1;
        else     a_rx_ack = 1'b1;
        @(negedge clk);
        a_rx_ack = 1'b0;
        b_rx_ack = 1'b0;
    endtask

    logic        line  [0:399];
    logic        busyl [0:399];
    logic [19:0] v20;
    logic [19:0] e20;
    logic [10:0] v11;
    logic [10:0] e11;
    logic [11:0] fr;
    int          n;

    initial begin
        reset_n = 1'b0;
        a_loop = 1'b0; a_rxd_drv = 1'b1; a_rx_ack = 1'b0; a_tx_data = '0; a_tx_wr = 1'b0; a_err_clr = 1'b0;
        b_rxd_drv = 1'b1; b_rx_ack = 1'b0; b_tx_data = '0; b_tx_wr = 1'b0; b_err_clr = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_a_outs", {a_txd, a_rx_avail, a_rx_level, a_tx_busy, a_tx_full, a_rx_data},
              {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00});
        check("rst_a_flags", {a_ferr, a_perr, a_ovr, a_drop}, 4'b0000);
        check("rst_b_txd", b_txd, 1'b1);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Loopback 8N1: two bytes back to back.
        a_loop = 1'b1;
        a_tx_data = 8'hA5; a_tx_wr = 1'b1; qa.push_back(8'hA5); @(negedge clk);
        a_tx_data = 8'h3C; qa.push_back(8'h3C); @(negedge clk);
        a_tx_wr = 1'b0;
        n = 0;
        while (a_txd && n < 100) begin @(negedge clk); n++; end
        check("lb_start_seen", a_txd, 1'b0);
        for (int i = 0; i < 400; i++) begin line[i] = a_txd; @(negedge clk); end
        n = 0;
        while (n < 40 && !line[n]) n++;
        check("lb_start_len", n, 16);
        for (int k = 0; k < 20; k++) v20[k] = line[16*k + 8];
        e20 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        check("lb_line", v20, e20);
        check("lb_frame160", {line[159], line[160]}, 2'b10);
        check("lb_level", a_rx_level, 3'd2);
        pop_rx(1'b0, "lb_b0");
        pop_rx(1'b0, "lb_b1");
        check("lb_empty", a_rx_avail, 1'b0);
        check("lb_errs", {a_ferr, a_perr, a_ovr, a_drop}, 4'b0000);
        a_loop = 1'b0;

        // 7O2 transmit; bit 7 of the written byte must be ignored.
        b_tx_data = 8'hC1; b_tx_wr = 1'b1; @(negedge clk);
        b_tx_wr = 1'b0;
        n = 0;
        while (b_txd && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 200; i++) begin line[i] = b_txd; busyl[i] = b_tx_busy; @(negedge clk); end
        for (int k = 0; k < 11; k++) v11[k] = line[16*k + 8];
        e11 = {1'b1, 1'b1, 1'b1, 7'h41, 1'b0};
        check("b_line", v11, e11);
        check("b_busy176", {busyl[175], busyl[176]}, 2'b10);

        // 7O2 receive with wrong (even) parity bit.
        fr = {1'b0, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0};
        qb.push_back(8'h41);
        send_frame(1'b1, fr, 11);
        repeat (4) @(negedge clk);
        check("b_perr", {b_perr, b_ferr}, 2'b10);
        pop_rx(1'b1, "b_par_data");

        // Framing error on A: stop bit low (shortened so no break is seen afterwards).
        fr = {3'b000, 8'h5A, 1'b0};
        qa.push_back(8'h5A);
        send_frame(1'b0, fr, 9);
        a_rxd_drv = 1'b0;
        repeat (10) @(negedge clk);
        a_rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_set", a_ferr, 1'b1);
        pop_rx(1'b0, "ferr_data");
        a_err_clr = 1'b1; @(negedge clk); a_err_clr = 1'b0;
        check("ferr_clr", a_ferr, 1'b0);

        // Overrun on depth-4 RX FIFO.
        for (int d = 1; d <= 5; d++) begin
            fr = {3'b001, 8'(d), 1'b0};
            if (d <= 4) qa.push_back(8'(d));
            send_frame(1'b0, fr, 10);
        end
        repeat (4) @(negedge clk);
        check("ovr_level", a_rx_level, 3'd4);
        check("ovr_flags", {a_ovr, a_ferr}, 2'b10);
        for (int d = 1; d <= 4; d++) pop_rx(1'b0, "ovr_data");
        check("ovr_empty", a_rx_avail, 1'b0);
        a_err_clr = 1'b1; @(negedge clk); a_err_clr = 1'b0;

        // TX full: six writes in a row; the sixth is dropped while err_clr is also high.
        for (int i = 0; i < 6; i++) begin
            a_tx_data = 8'h10 + 8'(i); a_tx_wr = 1'b1; a_err_clr = (i == 5);
            @(negedge clk);
        end
        a_tx_wr = 1'b0; a_err_clr = 1'b0;
        check("txf_full", a_tx_full, 1'b1);
        check("txf_drop_set_wins", a_drop, 1'b1);
        n = 0;
        while (a_tx_busy && n < 2000) begin @(negedge clk); n++; end
        check("txf_busy_len", n, 796);
        a_err_clr = 1'b1; @(negedge clk); a_err_clr = 1'b0;
        check("txf_drop_clr", a_drop, 1'b0);

        // Glitch: 3-clk low pulse must not produce a byte or flag.
        a_rxd_drv = 1'b0; repeat (3) @(negedge clk); a_rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch", {a_rx_avail, a_ferr, a_perr, a_ovr, a_drop}, 5'b00000);

        // Reset in the middle of a TX frame.
        a_tx_data = 8'h00; a_tx_wr = 1'b1; @(negedge clk);
        a_tx_data = 8'h55; @(negedge clk);
        a_tx_wr = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_pre", a_txd, 1'b0);
        reset_n = 1'b0; @(negedge clk);
        check("rst_mid_txd", {a_txd, a_tx_busy}, 2'b10);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 400; i++) begin if (a_txd) n++; @(negedge clk); end
        check("rst_mid_idle", n, 400);
        check("rst_mid_state", {a_tx_busy, a_rx_avail, a_rx_level}, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
